control_sequencer: RTL and testbench
====================================

# control_sequencer

Control sequencer for the 8-bit accumulator machine. It steps a fetch/execute state machine and decodes the 4-bit opcode from the instruction register into the per-cycle control word. That control word drives the program counter, MAR, RAM, IR, accumulator, B register, add/subtract unit and output register. It sits beside the shared 8-bit bus as the only source of load/enable strobes.

## Interface
- OP_W, 4, opcode width (IR upper nibble)
- CNT_W, 8, retired-instruction counter width
- CLK  in  1  system clock; all state changes on rising edge
- CLR  in  1  reset: synchronous and active-high; one clock; sampled on rising edge of CLK
- IR_op  in  OP_W  opcode from instruction register; valid from T4 onward
- CP  out  1  program counter increment
- EP  out  1  program counter drives bus
- LM  out  1  load MAR from bus
- CE  out  1  RAM drives bus
- LI  out  1  load IR from bus
- EI  out  1  IR operand nibble drives bus
- LA  out  1  load accumulator from bus
- EA  out  1  accumulator drives bus
- LB  out  1  load B register from bus
- SU  out  1  add/subtract select to ALU (1 = subtract)
- ALU_OE  out  1  ALU result-register enable (ALU captures sum at end of this cycle)
- EU  out  1  ALU result register drives bus
- LO  out  1  load output register
- HLT  out  1  machine halted
- T_state  out  7  one-hot current state, bit0 = T1
- INSTR_CNT  out  CNT_W  instructions retired, wraps

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111; all others NOP.
- States T1..T7 plus HALT.
- Outputs are a combinational decode of the registered state and IR_op. Control signals not listed for a state are 0.
- Fetch, identical for every opcode:
  - T1: EP, LM
  - T2: CP
  - T3: CE, LI
- LDA:
  - T4: EI, LM
  - T5: CE, LA, then T1
- ADD/SUB (SU = 1 for SUB, held T6–T7):
  - T4: EI, LM
  - T5: CE, LB
  - T6: ALU_OE
  - T7: EU, LA, then T1
- OUT:
  - T4: EA, LO, then T1
- NOP:
  - T4: no strobes, then T1
- HLT:
  - T4 goes to HALT.
  - HALT: HLT=1, all strobes 0, T_state=0.
  - HALT is left only by CLR.
- INSTR_CNT increments on the last cycle of every instruction, including NOP. The HLT instruction itself counts once, on entry to HALT. Wraps 2^CNT_W−1 → 0.
- At most one of EP, CE, EI, EA, EU is 1 in any cycle. A violation is a design error.

## Timing
- CLR high at a rising edge:
  - next state T1, INSTR_CNT=0, HLT=0
  - while CLR is high, all strobes are forced to 0 and T_state=0000001
  - CLR mid-instruction or in HALT aborts immediately; no partial writes after that edge
- First fetch strobes (EP, LM) appear in the cycle after CLR deasserts.
- Instruction lengths: LDA 5 cycles, ADD/SUB 7 cycles, OUT 4 cycles, NOP 4 cycles.
- Sum latency:
  - B is loaded at end of T5.
  - ALU result is combinationally valid during T6.
  - ALU registers it at end of T6 (ALU_OE).
  - Accumulator loads it at end of T7.
- IR_op is sampled only in T4–T7 and ignored in T1–T3. A change of IR_op mid-execute is not permitted. The decode follows IR_op combinationally, with no latching.

## Structure
- Shared package ctrl_pkg holds:
  - opcode localparams
  - state one-hot encodings
  - control-word bit indices, so the datapath top and the bench decode identically
- No sub-module: one state register, one counter and one decode block live in control_sequencer.

## Test plan
- Reset then LDA (IR_op=0000) → EP+LM in cycle 1, CP in cycle 2, CE+LI in cycle 3, EI+LM in cycle 4, CE+LA in cycle 5; T1 in cycle 6; INSTR_CNT=1.
- ADD then SUB with datapath model: Acc=0x05, B mem=0x03 → Acc=0x08 after 7 cycles; then SUB 0x03 → Acc=0x05; SU=1 only during T6–T7 of SUB.
- OUT (1110) and NOP (0101) → 4 cycles each; LO pulses once in T4 of OUT only; INSTR_CNT advances by 2.
- HLT (1111) → HLT=1 from cycle 5; strobes stay 0 for 20 cycles; CLR → T1, HLT=0, INSTR_CNT=0.
- CLR asserted in T6 of ADD → no LA pulse; Acc unchanged; restart at T1.
- Run 256 NOPs → INSTR_CNT wraps 0xFF→0x00. Bus-driver exclusivity is checked every cycle across all scenarios.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-machine control sequencer:
// opcode values, one-hot state encodings and control-word bit positions.
package ctrl_pkg;

    localparam int OP_W_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Bits 0..6 are T1..T7 and are exported directly as T_state; HALT sits
    // on bit 7 so T_state reads all-zero while halted.
    typedef enum logic [7:0] {
        ST_T1   = 8'b0000_0001,
        ST_T2   = 8'b0000_0010,
        ST_T3   = 8'b0000_0100,
        ST_T4   = 8'b0000_1000,
        ST_T5   = 8'b0001_0000,
        ST_T6   = 8'b0010_0000,
        ST_T7   = 8'b0100_0000,
        ST_HALT = 8'b1000_0000
    } state_t;

    // Control-word bit positions, shared by the sequencer and its consumers.
    localparam int CW_CP     = 0;
    localparam int CW_EP     = 1;
    localparam int CW_LM     = 2;
    localparam int CW_CE     = 3;
    localparam int CW_LI     = 4;
    localparam int CW_EI     = 5;
    localparam int CW_LA     = 6;
    localparam int CW_EA     = 7;
    localparam int CW_LB     = 8;
    localparam int CW_SU     = 9;
    localparam int CW_ALU_OE = 10;
    localparam int CW_EU     = 11;
    localparam int CW_LO     = 12;
    localparam int CW_W      = 13;

    typedef enum logic [2:0] {
        CLS_LDA,
        CLS_ADD,
        CLS_SUB,
        CLS_OUT,
        CLS_HLT,
        CLS_NOP
    } op_class_t;

    // Collapse the raw opcode into the handful of behaviours the FSM cares about.
    function automatic op_class_t classify(input logic [3:0] op);
        case (op)
            OP_LDA:  return CLS_LDA;
            OP_ADD:  return CLS_ADD;
            OP_SUB:  return CLS_SUB;
            OP_OUT:  return CLS_OUT;
            OP_HLT:  return CLS_HLT;
            default: return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator machine. Steps T1..T7
// (plus HALT) and decodes the opcode into the per-cycle control word.
//
// state | meaning
// T1    | PC onto bus, load MAR
// T2    | increment PC
// T3    | RAM onto bus, load IR
// T4    | execute step 1 (operand address / OUT / NOP / HLT dispatch)
// T5    | execute step 2 (RAM read into A or B)
// T6    | ALU result captured
// T7    | ALU result into accumulator
// HALT  | stopped; only CLR leaves
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [OP_W-1:0]  IR_op,
    output logic             CP,
    output logic             EP,
    output logic             LM,
    output logic             CE,
    output logic             LI,
    output logic             EI,
    output logic             LA,
    output logic             EA,
    output logic             LB,
    output logic             SU,
    output logic             ALU_OE,
    output logic             EU,
    output logic             LO,
    output logic             HLT,
    output logic [6:0]       T_state,
    output logic [CNT_W-1:0] INSTR_CNT
);

    state_t             state;
    state_t             state_nxt;
    op_class_t          op_cls;
    logic               last_cycle;
    logic [CW_W-1:0]    cw;
    logic [CNT_W-1:0]   instr_cnt;

    assign op_cls = classify(IR_op);

    // State register; CLR restarts the fetch from T1.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= ST_T1;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; T1..T3 never look at IR_op.
    always_comb begin
        state_nxt = ST_T1;
        case (state)
            ST_T1: state_nxt = ST_T2;
            ST_T2: state_nxt = ST_T3;
            ST_T3: state_nxt = ST_T4;
            ST_T4: begin
                case (op_cls)
                    CLS_LDA, CLS_ADD, CLS_SUB: state_nxt = ST_T5;
                    CLS_HLT:                   state_nxt = ST_HALT;
                    default:                   state_nxt = ST_T1;
                endcase
            end
            ST_T5: begin
                if (op_cls == CLS_ADD || op_cls == CLS_SUB) begin
                    state_nxt = ST_T6;
                end else begin
                    state_nxt = ST_T1;
                end
            end
            ST_T6:   state_nxt = ST_T7;
            ST_T7:   state_nxt = ST_T1;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_T1;
        endcase
    end

    // Final cycle of each instruction; HLT retires on its way into HALT.
    always_comb begin
        last_cycle = 1'b0;
        case (state)
            ST_T4: last_cycle = (op_cls == CLS_OUT) || (op_cls == CLS_NOP) ||
                                (op_cls == CLS_HLT);
            ST_T5: last_cycle = (op_cls == CLS_LDA);
            ST_T7: last_cycle = 1'b1;
            default: last_cycle = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            instr_cnt <= '0;
        end else if (last_cycle) begin
            instr_cnt <= instr_cnt + 1'b1;
        end
    end

    // Control-word decode; CLR masks every strobe so an aborted
    // instruction cannot write anything on the reset edge.
    always_comb begin
        cw = '0;
        if (!CLR) begin
            case (state)
                ST_T1: begin
                    cw[CW_EP] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end
                ST_T2: cw[CW_CP] = 1'b1;
                ST_T3: begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LI] = 1'b1;
                end
                ST_T4: begin
                    case (op_cls)
                        CLS_LDA, CLS_ADD, CLS_SUB: begin
                            cw[CW_EI] = 1'b1;
                            cw[CW_LM] = 1'b1;
                        end
                        CLS_OUT: begin
                            cw[CW_EA] = 1'b1;
                            cw[CW_LO] = 1'b1;
                        end
                        default: cw = '0;
                    endcase
                end
                ST_T5: begin
                    if (op_cls == CLS_LDA) begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end else if (op_cls == CLS_ADD || op_cls == CLS_SUB) begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                end
                ST_T6: begin
                    cw[CW_ALU_OE] = 1'b1;
                    cw[CW_SU]     = (op_cls == CLS_SUB);
                end
                ST_T7: begin
                    cw[CW_EU] = 1'b1;
                    cw[CW_LA] = 1'b1;
                    cw[CW_SU] = (op_cls == CLS_SUB);
                end
                default: cw = '0;
            endcase
        end
    end

    // Status outputs; T_state reads T1 while CLR is held.
    always_comb begin
        HLT     = (state == ST_HALT) && !CLR;
        T_state = CLR ? 7'b000_0001 : state[6:0];
    end

    assign CP        = cw[CW_CP];
    assign EP        = cw[CW_EP];
    assign LM        = cw[CW_LM];
    assign CE        = cw[CW_CE];
    assign LI        = cw[CW_LI];
    assign EI        = cw[CW_EI];
    assign LA        = cw[CW_LA];
    assign EA        = cw[CW_EA];
    assign LB        = cw[CW_LB];
    assign SU        = cw[CW_SU];
    assign ALU_OE    = cw[CW_ALU_OE];
    assign EU        = cw[CW_EU];
    assign LO        = cw[CW_LO];
    assign INSTR_CNT = instr_cnt;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small bus/register model.
module tb_control_sequencer;
    import ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] IR_op = 4'b0000;
    logic CP, EP, LM, CE, LI, EI, LA, EA, LB, SU, ALU_OE, EU, LO, HLT;
    logic [6:0] T_state;
    logic [7:0] INSTR_CNT;

    int checks = 0;
    int fails  = 0;

    logic [CW_W-1:0] obs_cw;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] bus, acc = 8'h00, breg = 8'h00, alu_reg = 8'h00, out_reg = 8'h00;
    int lo_pulses = 0;
    int la_pulses = 0;

    localparam logic [CW_W-1:0] W_EPLM  = (13'd1 << CW_EP) | (13'd1 << CW_LM);
    localparam logic [CW_W-1:0] W_CP    = (13'd1 << CW_CP);
    localparam logic [CW_W-1:0] W_CELI  = (13'd1 << CW_CE) | (13'd1 << CW_LI);
    localparam logic [CW_W-1:0] W_EILM  = (13'd1 << CW_EI) | (13'd1 << CW_LM);
    localparam logic [CW_W-1:0] W_CELA  = (13'd1 << CW_CE) | (13'd1 << CW_LA);
    localparam logic [CW_W-1:0] W_CELB  = (13'd1 << CW_CE) | (13'd1 << CW_LB);
    localparam logic [CW_W-1:0] W_ALU   = (13'd1 << CW_ALU_OE);
    localparam logic [CW_W-1:0] W_EULA  = (13'd1 << CW_EU) | (13'd1 << CW_LA);
    localparam logic [CW_W-1:0] W_SU    = (13'd1 << CW_SU);
    localparam logic [CW_W-1:0] W_EALO  = (13'd1 << CW_EA) | (13'd1 << CW_LO);

    control_sequencer dut (
        .CLK(CLK), .CLR(CLR), .IR_op(IR_op),
        .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI), .LA(LA),
        .EA(EA), .LB(LB), .SU(SU), .ALU_OE(ALU_OE), .EU(EU), .LO(LO),
        .HLT(HLT), .T_state(T_state), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        obs_cw            = '0;
        obs_cw[CW_CP]     = CP;
        obs_cw[CW_EP]     = EP;
        obs_cw[CW_LM]     = LM;
        obs_cw[CW_CE]     = CE;
        obs_cw[CW_LI]     = LI;
        obs_cw[CW_EI]     = EI;
        obs_cw[CW_LA]     = LA;
        obs_cw[CW_EA]     = EA;
        obs_cw[CW_LB]     = LB;
        obs_cw[CW_SU]     = SU;
        obs_cw[CW_ALU_OE] = ALU_OE;
        obs_cw[CW_EU]     = EU;
        obs_cw[CW_LO]     = LO;
    end

    always_comb begin
        bus = 8'h00;
        if (EP) bus = 8'h00;
        else if (CE) bus = mem_data;
        else if (EI) bus = 8'h0E;
        else if (EA) bus = acc;
        else if (EU) bus = alu_reg;
    end

    // Datapath model driven purely by the strobes.
    always @(posedge CLK) begin
        if (LA) begin acc <= bus; la_pulses <= la_pulses + 1; end
        if (LB) breg <= bus;
        if (ALU_OE) alu_reg <= SU ? (acc - breg) : (acc + breg);
        if (LO) begin out_reg <= bus; lo_pulses <= lo_pulses + 1; end
    end

    // Bus-driver exclusivity, every cycle.
    always @(negedge CLK) begin
        checks++;
        if ((int'(EP) + int'(CE) + int'(EI) + int'(EA) + int'(EU)) > 1) begin
            fails++;
            $display("FAIL bus_exclusive t=%0t got EP=%b CE=%b EI=%b EA=%b EU=%b exp at most one",
                     $time, EP, CE, EI, EA, EU);
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        tick();
        CLR = 1'b1;
        #1;
        checks++;
        if (T_state !== 7'b000_0001 || obs_cw !== '0 || HLT !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold got T=%b cw=%h hlt=%b exp T=0000001 cw=0 hlt=0", T_state, obs_cw, HLT);
        end
        tick();
        CLR = 1'b0;
        #1;
        checks++;
        if (T_state !== 7'b000_0001 || INSTR_CNT !== 8'h00 || obs_cw !== W_EPLM) begin
            fails++;
            $display("FAIL reset_release got T=%b cnt=%h cw=%h exp T=0000001 cnt=00 cw=%h",
                     T_state, INSTR_CNT, obs_cw, W_EPLM);
        end
    endtask

    task automatic test_lda;
        logic [CW_W-1:0] exp_cw [5];
        exp_cw = '{W_EPLM, W_CP, W_CELI, W_EILM, W_CELA};
        IR_op = OP_LDA;
        mem_data = 8'h05;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_cw !== exp_cw[i] || T_state !== (7'd1 << i)) begin
                fails++;
                $display("FAIL lda_cycle%0d got cw=%h T=%b exp cw=%h T=%b", i + 1, obs_cw, T_state, exp_cw[i], 7'd1 << i);
            end
            tick();
        end
        checks++;
        if (T_state !== 7'b000_0001 || INSTR_CNT !== 8'h01 || acc !== 8'h05) begin
            fails++;
            $display("FAIL lda_done got T=%b cnt=%h acc=%h exp T=0000001 cnt=01 acc=05", T_state, INSTR_CNT, acc);
        end
    endtask

    task automatic test_add_sub;
        logic [CW_W-1:0] exp_cw [7];
        exp_cw = '{W_EPLM, W_CP, W_CELI, W_EILM, W_CELB, W_ALU, W_EULA};
        mem_data = 8'h03;
        IR_op = OP_ADD;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs_cw !== exp_cw[i] || T_state !== (7'd1 << i)) begin
                fails++;
                $display("FAIL add_cycle%0d got cw=%h T=%b exp cw=%h T=%b", i + 1, obs_cw, T_state, exp_cw[i], 7'd1 << i);
            end
            tick();
        end
        checks++;
        if (acc !== 8'h08 || INSTR_CNT !== 8'h02 || T_state !== 7'b000_0001) begin
            fails++;
            $display("FAIL add_done got acc=%h cnt=%h T=%b exp acc=08 cnt=02 T=0000001", acc, INSTR_CNT, T_state);
        end
        IR_op = OP_SUB;
        for (int i = 0; i < 7; i++) begin
            logic [CW_W-1:0] e;
            e = exp_cw[i] | ((i >= 5) ? W_SU : '0);
            checks++;
            if (obs_cw !== e || T_state !== (7'd1 << i)) begin
                fails++;
                $display("FAIL sub_cycle%0d got cw=%h T=%b exp cw=%h T=%b", i + 1, obs_cw, T_state, e, 7'd1 << i);
            end
            tick();
        end
        checks++;
        if (acc !== 8'h05 || INSTR_CNT !== 8'h03) begin
            fails++;
            $display("FAIL sub_done got acc=%h cnt=%h exp acc=05 cnt=03", acc, INSTR_CNT);
        end
    endtask

    task automatic test_out_nop;
        logic [CW_W-1:0] exp_out [4];
        logic [CW_W-1:0] exp_nop [4];
        exp_out = '{W_EPLM, W_CP, W_CELI, W_EALO};
        exp_nop = '{W_EPLM, W_CP, W_CELI, '0};
        lo_pulses = 0;
        IR_op = OP_OUT;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_cw !== exp_out[i] || T_state !== (7'd1 << i)) begin
                fails++;
                $display("FAIL out_cycle%0d got cw=%h T=%b exp cw=%h", i + 1, obs_cw, T_state, exp_out[i]);
            end
            tick();
        end
        IR_op = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_cw !== exp_nop[i] || T_state !== (7'd1 << i)) begin
                fails++;
                $display("FAIL nop_cycle%0d got cw=%h T=%b exp cw=%h", i + 1, obs_cw, T_state, exp_nop[i]);
            end
            tick();
        end
        checks++;
        if (lo_pulses !== 1 || out_reg !== 8'h05 || INSTR_CNT !== 8'h05 || T_state !== 7'b000_0001) begin
            fails++;
            $display("FAIL out_nop_done got lo=%0d out=%h cnt=%h T=%b exp lo=1 out=05 cnt=05 T=0000001",
                     lo_pulses, out_reg, INSTR_CNT, T_state);
        end
    endtask

    task automatic test_halt;
        IR_op = OP_HLT;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (HLT !== 1'b1 || T_state !== 7'b0 || obs_cw !== '0 || INSTR_CNT !== 8'h06) begin
            fails++;
            $display("FAIL halt_entry got hlt=%b T=%b cw=%h cnt=%h exp hlt=1 T=0 cw=0 cnt=06",
                     HLT, T_state, obs_cw, INSTR_CNT);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (HLT !== 1'b1 || obs_cw !== '0 || T_state !== 7'b0 || INSTR_CNT !== 8'h06) begin
                fails++;
                $display("FAIL halt_hold%0d got hlt=%b cw=%h T=%b cnt=%h exp hlt=1 cw=0 T=0 cnt=06",
                         i, HLT, obs_cw, T_state, INSTR_CNT);
            end
        end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        #1;
        checks++;
        if (HLT !== 1'b0 || T_state !== 7'b000_0001 || INSTR_CNT !== 8'h00 || obs_cw !== W_EPLM) begin
            fails++;
            $display("FAIL halt_clear got hlt=%b T=%b cnt=%h cw=%h exp hlt=0 T=0000001 cnt=00 cw=%h",
                     HLT, T_state, INSTR_CNT, obs_cw, W_EPLM);
        end
    endtask

    task automatic test_abort;
        int la_before;
        mem_data = 8'h03;
        IR_op = OP_ADD;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (T_state !== 7'b010_0000) begin
            fails++;
            $display("FAIL abort_at_t6 got T=%b exp T=0100000", T_state);
        end
        la_before = la_pulses;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        #1;
        tick();
        checks++;
        if (la_pulses !== la_before || acc !== 8'h05 || INSTR_CNT !== 8'h00 || T_state !== 7'b000_0010) begin
            fails++;
            $display("FAIL abort_result got la=%0d acc=%h cnt=%h T=%b exp la=%0d acc=05 cnt=00 T=0000010",
                     la_pulses - la_before + la_before, acc, INSTR_CNT, T_state, la_before);
        end
        // Finish the restarted fetch as a NOP so the next test starts in T1.
        IR_op = 4'b0101;
        tick();
        tick();
        tick();
        checks++;
        if (T_state !== 7'b000_0001 || INSTR_CNT !== 8'h01) begin
            fails++;
            $display("FAIL abort_restart got T=%b cnt=%h exp T=0000001 cnt=01", T_state, INSTR_CNT);
        end
    endtask

    task automatic test_wrap;
        IR_op = 4'b0101;
        for (int n = 0; n < 254; n++) begin
            for (int i = 0; i < 4; i++) tick();
        end
        checks++;
        if (INSTR_CNT !== 8'hFF) begin
            fails++;
            $display("FAIL wrap_ff got cnt=%h exp cnt=ff", INSTR_CNT);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (INSTR_CNT !== 8'h00 || T_state !== 7'b000_0001) begin
            fails++;
            $display("FAIL wrap_00 got cnt=%h T=%b exp cnt=00 T=0000001", INSTR_CNT, T_state);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_out_nop();
        test_halt();
        test_abort();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
